life_pixel_renderer: RTL and testbench
======================================

# life_pixel_renderer

Pixel-colour stage directly downstream of the 1280x1024 VESA sync generator. Maps each raster coordinate to a Game of Life cell, reads that cell from a synchronous-read, double-buffered cell RAM, and drives 12-bit RGB with sync delayed to match. At a frame boundary it swaps the displayed buffer on request from the life engine.

## Interface

- HLEN, 1280, active pixels per line
- VHEIGHT, 1024, active lines per frame
- CELL_SHIFT, 4, log2 of cell size in pixels (16x16 cells)
- GRID_W, 80, cells per row (HLEN >> CELL_SHIFT)
- ADDR_W, 13, cell address width per buffer (GRID_W*64 = 5120 cells)
- GRID_EN, 1, 1 = draw grid lines
- ALIVE_RGB, 12'hFFF / DEAD_RGB, 12'h000 / GRID_RGB, 12'h444, colours as {R[3:0],G[3:0],B[3:0]}

- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- x  in  11  current column from sync generator
- y  in  11  current line from sync generator
- hsync_in  in  1  registered Hsync from sync generator, active low
- vsync_in  in  1  registered Vsync from sync generator, active low
- frame  in  1  one-cycle pulse on the last pixel of the frame
- swap_req  in  1  level; engine has finished the back buffer
- swap_ack  out  1  one-cycle pulse; swap done
- rd_en  out  1  cell RAM read enable
- rd_addr  out  ADDR_W+1  {disp_buf, row*GRID_W+col}
- rd_data  in  1  cell state, valid one cycle after rd_en/rd_addr
- rgb  out  12  pixel colour
- hsync_out  out  1  hsync_in delayed to align with rgb
- vsync_out  out  1  vsync_in delayed to align with rgb

## Operation

- Stage 1 (registered from x,y): col = x >> CELL_SHIFT, row = y >> CELL_SHIFT; rd_addr = {disp_buf, row*GRID_W + col}. The multiply is by a constant only, truncated to ADDR_W bits. active1 = (x < HLEN) && (y < VHEIGHT). grid1 = GRID_EN && (x[CELL_SHIFT-1:0]==0 || y[CELL_SHIFT-1:0]==0). rd_en = active1.
- When inactive, rd_en = 0 and rd_addr holds its last value. The RAM output is ignored.
- Stage 2: active2 and grid2 are delayed copies. rd_data is valid this cycle.
- Stage 3 (output register): rgb = !active2 ? 0 : grid2 ? GRID_RGB : rd_data ? ALIVE_RGB : DEAD_RGB.
- Grid priority: a grid pixel overrides cell state.
- Sync: hsync_in and vsync_in pass through a 3-deep shift register. No logic is applied to sync.
- Buffer swap: disp_buf is a 1-bit register.
  - On a cycle with frame==1 && swap_req==1: disp_buf toggles and swap_ack = 1 on the next cycle only.
  - swap_req without frame has no effect. frame without swap_req means no swap.
  - The engine must drop swap_req on swap_ack. If swap_req is still high at the next frame, a second swap occurs; this is legal.
- The swap takes effect at pixel (0,0) of the next frame. The frame cycle itself uses the old buffer, so no frame ever mixes buffers.

## Timing

- Latency: inputs at cycle n produce rgb, hsync_out and vsync_out at cycle n+3. rd_addr and rd_en appear at n+1.
- rd_data is sampled at n+2. The RAM must have exactly 1-cycle read latency.
- swap_ack is asserted at n+1 for frame/swap_req at n, for 1 cycle.
- Reset values (asynchronous, immediate):
  - rgb = 0, rd_en = 0, rd_addr = 0, swap_ack = 0, disp_buf = 0
  - hsync_out = 1, vsync_out = 1, all sync pipeline stages = 1
  - active1/2 = 0
- Reset mid-frame: outputs go to reset values at once. After release, the first 3 output cycles are black with sync high; normal data follows.
- Reset asserted while swap_req is pending: no swap, no ack. disp_buf = 0.
- Wrap-around: x=HLEN-1 → col=GRID_W-1. Last active pixel (1279,1023) → rd_addr low bits = 5119. Blanking coordinates never reach rgb as non-zero.

## Test plan

- Reset check: hold rst high → rgb=0, hsync_out=vsync_out=1, rd_en=0, swap_ack=0. Release during mid-line → first 3 outputs are black with sync 1.
- Address map: drive (x,y)=(17,33) → rd_addr=({0,2*80+1})=161 one cycle later. (1279,1023) → 5119. (1280,0) → rd_en=0, rgb=0 at n+3.
- Colour/latency: RAM model returns 1 for cell 161. Pixel (17,33) gives rgb=12'hFFF at n+3. (16,33) gives 12'h444 (grid). With GRID_EN=0, (16,33) gives 12'hFFF.
- Sync alignment: drive sync generator waveform → hsync_out/vsync_out equal inputs delayed exactly 3 cycles, across full 1688x1066 frame.
- Swap: swap_req=1 mid-frame → no change until frame pulse. Then swap_ack for 1 cycle, and the next (0,0) read has rd_addr MSB=1. With swap_req held high over 2 frames → 2 acks and MSB back to 0.
- Swap vs reset: assert rst on the frame cycle with swap_req=1 → swap_ack stays 0 and disp_buf=0.

Source files
------------

// File: rtl/life_pixel_renderer.sv
// Pixel-colour stage behind the VESA sync generator: maps raster coordinates to Game of Life
// cells, reads them from a double-buffered cell RAM and drives RGB with sync delayed by 3 cycles.
module life_pixel_renderer #(
    parameter int          HLEN       = 1280,
    parameter int          VHEIGHT    = 1024,
    parameter int          CELL_SHIFT = 4,
    parameter int          GRID_W     = 80,
    parameter int          ADDR_W     = 13,
    parameter bit          GRID_EN    = 1'b1,
    parameter logic [11:0] ALIVE_RGB  = 12'hFFF,
    parameter logic [11:0] DEAD_RGB   = 12'h000,
    parameter logic [11:0] GRID_RGB   = 12'h444
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [10:0]       i_x,
    input  logic [10:0]       i_y,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_frame,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic              o_rd_en,
    output logic [ADDR_W:0]   o_rd_addr,
    input  logic              i_rd_data,
    output logic [11:0]       o_rgb,
    output logic              o_hsync,
    output logic              o_vsync
);

    localparam logic [10:0]       HLEN_C    = 11'(HLEN);
    localparam logic [10:0]       VHEIGHT_C = 11'(VHEIGHT);
    localparam logic [ADDR_W-1:0] GRID_W_C  = ADDR_W'(GRID_W);

    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_cell;
    logic              w_active;
    logic              w_grid;
    logic [11:0]       w_pix_rgb;

    logic              r_disp_buf;
    logic              r_swap_ack;
    logic              r_rd_en;
    logic [ADDR_W:0]   r_rd_addr;
    logic              r_active1;
    logic              r_grid1;
    logic              r_active2;
    logic              r_grid2;
    logic [11:0]       r_rgb;
    logic [2:0]        r_hsync_pipe;
    logic [2:0]        r_vsync_pipe;

    assign w_col    = ADDR_W'(i_x >> CELL_SHIFT);
    assign w_row    = ADDR_W'(i_y >> CELL_SHIFT);
    assign w_cell   = w_row * GRID_W_C + w_col;
    assign w_active = (i_x < HLEN_C) && (i_y < VHEIGHT_C);
    assign w_grid   = GRID_EN && ((i_x[CELL_SHIFT-1:0] == '0) || (i_y[CELL_SHIFT-1:0] == '0));

    // Colour select for the output register; grid lines win over cell state.
    always_comb begin
        w_pix_rgb = 12'h000;
        if (!r_active2) begin
            w_pix_rgb = 12'h000;
        end else if (r_grid2) begin
            w_pix_rgb = GRID_RGB;
        end else if (i_rd_data) begin
            w_pix_rgb = ALIVE_RGB;
        end else begin
            w_pix_rgb = DEAD_RGB;
        end
    end

    // Displayed-buffer select; toggling on the frame cycle means the next read is pixel (0,0).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_disp_buf <= 1'b0;
            r_swap_ack <= 1'b0;
        end else if (i_frame && i_swap_req) begin
            r_disp_buf <= ~r_disp_buf;
            r_swap_ack <= 1'b1;
        end else begin
            r_disp_buf <= r_disp_buf;
            r_swap_ack <= 1'b0;
        end
    end

    // Stage 1: RAM address/enable; the address holds through blanking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_active1 <= 1'b0;
            r_grid1   <= 1'b0;
        end else begin
            r_rd_en   <= w_active;
            r_active1 <= w_active;
            r_grid1   <= w_grid;
            if (w_active) begin
                r_rd_addr <= {r_disp_buf, w_cell};
            end else begin
                r_rd_addr <= r_rd_addr;
            end
        end
    end

    // Stage 2 (RAM data arrives) and stage 3 (colour register).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active2 <= 1'b0;
            r_grid2   <= 1'b0;
            r_rgb     <= 12'h000;
        end else begin
            r_active2 <= r_active1;
            r_grid2   <= r_grid1;
            r_rgb     <= w_pix_rgb;
        end
    end

    // Sync delay line matching the three pixel stages; idles high (inactive).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hsync_pipe <= 3'b111;
            r_vsync_pipe <= 3'b111;
        end else begin
            r_hsync_pipe <= {r_hsync_pipe[1:0], i_hsync};
            r_vsync_pipe <= {r_vsync_pipe[1:0], i_vsync};
        end
    end

    assign o_swap_ack = r_swap_ack;
    assign o_rd_en    = r_rd_en;
    assign o_rd_addr  = r_rd_addr;
    assign o_rgb      = r_rgb;
    assign o_hsync    = r_hsync_pipe[2];
    assign o_vsync    = r_vsync_pipe[2];

endmodule

// File: tb/tb_life_pixel_renderer.sv
// Directed self-checking bench for life_pixel_renderer: address map, colour/latency, sync delay,
// buffer swap and reset behaviour, with a second instance built without grid lines.
module tb_life_pixel_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs_in;
    logic        vs_in;
    logic        frame;
    logic        swap_req;

    logic        swap_ack, rd_en, hs_out, vs_out;
    logic [13:0] rd_addr;
    logic [11:0] rgb;
    logic        rd_data = 1'b0;

    logic        swap_ack_b, rd_en_b, hs_out_b, vs_out_b;
    logic [13:0] rd_addr_b;
    logic [11:0] rgb_b;
    logic        rd_data_b = 1'b0;

    logic        mem [0:16383];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    life_pixel_renderer dut (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_hsync(hs_in), .i_vsync(vs_in),
        .i_frame(frame), .i_swap_req(swap_req), .o_swap_ack(swap_ack), .o_rd_en(rd_en),
        .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_rgb(rgb), .o_hsync(hs_out), .o_vsync(vs_out)
    );

    life_pixel_renderer #(.GRID_EN(1'b0)) dut_nogrid (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_hsync(hs_in), .i_vsync(vs_in),
        .i_frame(frame), .i_swap_req(swap_req), .o_swap_ack(swap_ack_b), .o_rd_en(rd_en_b),
        .o_rd_addr(rd_addr_b), .i_rd_data(rd_data_b), .o_rgb(rgb_b), .o_hsync(hs_out_b),
        .o_vsync(vs_out_b)
    );

    // Cell RAM models with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 9;
    int vx   [NV] = '{17, 16, 1279, 1280, 40, 0, 100, 33, 1279};
    int vy   [NV] = '{33, 33, 1023, 0, 20, 0, 1024, 48, 0};
    int vhs  [NV] = '{1, 0, 0, 1, 1, 0, 1, 1, 0};
    int vvs  [NV] = '{1, 1, 0, 0, 1, 1, 0, 1, 0};
    int vadr [NV] = '{161, 161, 5119, 5119, 82, 0, 0, 242, 79};
    int vren [NV] = '{1, 1, 1, 0, 1, 1, 0, 1, 1};
    int vrgb [NV] = '{'hFFF, 'h444, 'hFFF, 0, 0, 'h444, 0, 'h444, 'h444};
    int vrgbb[NV] = '{'hFFF, 'hFFF, 'hFFF, 0, 0, 0, 0, 'hFFF, 0};

    int hs_hist [40];
    int vs_hist [40];

    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = 1'b0;
        mem[161]      = 1'b1;
        mem[5119]     = 1'b1;
        mem[242]      = 1'b1;
        mem[8192+82]  = 1'b1;

        rst = 1'b1; x = 11'd17; y = 11'd33; hs_in = 1'b0; vs_in = 1'b0;
        frame = 1'b0; swap_req = 1'b1;
        tick(); tick();
        chk_eq("rst_rgb", 32'(rgb), 32'h0);
        chk_eq("rst_hsync", 32'(hs_out), 32'h1);
        chk_eq("rst_vsync", 32'(vs_out), 32'h1);
        chk_eq("rst_rd_en", 32'(rd_en), 32'h0);
        chk_eq("rst_rd_addr", 32'(rd_addr), 32'h0);
        chk_eq("rst_swap_ack", 32'(swap_ack), 32'h0);
        rst = 1'b0; swap_req = 1'b0;

        // Vector stream: address at +1, colour and sync at +3.
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                x = 11'(vx[i]); y = 11'(vy[i]); hs_in = 1'(vhs[i]); vs_in = 1'(vvs[i]);
            end else begin
                x = 11'd1280; y = 11'd1030; hs_in = 1'b1; vs_in = 1'b1;
            end
            tick();
            if (i < NV) begin
                chk_eq($sformatf("addr_v%0d", i), 32'(rd_addr), vadr[i]);
                chk_eq($sformatf("rd_en_v%0d", i), 32'(rd_en), vren[i]);
            end
            if (i >= 2) begin
                chk_eq($sformatf("rgb_v%0d", i-2), 32'(rgb), vrgb[i-2]);
                chk_eq($sformatf("rgb_nogrid_v%0d", i-2), 32'(rgb_b), vrgbb[i-2]);
                chk_eq($sformatf("hsync_v%0d", i-2), 32'(hs_out), vhs[i-2]);
                chk_eq($sformatf("vsync_v%0d", i-2), 32'(vs_out), vvs[i-2]);
            end else begin
                chk_eq($sformatf("post_rst_rgb%0d", i), 32'(rgb), 32'h0);
                chk_eq($sformatf("post_rst_hsync%0d", i), 32'(hs_out), 32'h1);
                chk_eq($sformatf("post_rst_vsync%0d", i), 32'(vs_out), 32'h1);
            end
        end

        // swap_req without frame: nothing happens.
        swap_req = 1'b1; x = 11'd17; y = 11'd33;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("swap_hold_ack", 32'(swap_ack), 32'h0);
            chk_eq("swap_hold_addr", 32'(rd_addr), 32'd161);
        end
        frame = 1'b1; x = 11'd1687; y = 11'd1065;
        tick();
        chk_eq("swap1_ack", 32'(swap_ack), 32'h1);
        chk_eq("swap1_rd_en", 32'(rd_en), 32'h0);
        frame = 1'b0; swap_req = 1'b0; x = 11'd0; y = 11'd0;
        tick();
        chk_eq("swap1_ack_drop", 32'(swap_ack), 32'h0);
        chk_eq("swap1_addr00", 32'(rd_addr), 32'd8192);
        x = 11'd40; y = 11'd20;
        tick();
        chk_eq("buf1_addr", 32'(rd_addr), 32'd8274);
        x = 11'd1280; y = 11'd0;
        tick(); tick();
        chk_eq("buf1_rgb", 32'(rgb), 32'hFFF);

        // swap_req held across two frame pulses: two acks, two toggles.
        swap_req = 1'b1; frame = 1'b1; x = 11'd1687; y = 11'd1065;
        tick();
        chk_eq("dbl_ack1", 32'(swap_ack), 32'h1);
        frame = 1'b0;
        tick();
        chk_eq("dbl_gap", 32'(swap_ack), 32'h0);
        frame = 1'b1;
        tick();
        chk_eq("dbl_ack2", 32'(swap_ack), 32'h1);
        frame = 1'b0; swap_req = 1'b0; x = 11'd0; y = 11'd0;
        tick();
        chk_eq("dbl_ack_drop", 32'(swap_ack), 32'h0);
        chk_eq("dbl_addr00", 32'(rd_addr), 32'd8192);

        // Reset on the frame cycle with a pending swap, mid-stream.
        x = 11'd40; y = 11'd20; hs_in = 1'b0; vs_in = 1'b0;
        tick(); tick(); tick();
        chk_eq("pre_rst_rgb", 32'(rgb), 32'hFFF);
        chk_eq("pre_rst_hsync", 32'(hs_out), 32'h0);
        frame = 1'b1; swap_req = 1'b1; x = 11'd1687; y = 11'd1065;
        #2 rst = 1'b1;
        #1;
        chk_eq("midrst_rgb", 32'(rgb), 32'h0);
        chk_eq("midrst_hsync", 32'(hs_out), 32'h1);
        chk_eq("midrst_vsync", 32'(vs_out), 32'h1);
        chk_eq("midrst_rd_en", 32'(rd_en), 32'h0);
        chk_eq("midrst_rd_addr", 32'(rd_addr), 32'h0);
        tick();
        chk_eq("rst_swap_ack", 32'(swap_ack), 32'h0);
        tick();
        frame = 1'b0; swap_req = 1'b0; rst = 1'b0; x = 11'd0; y = 11'd0;
        tick();
        chk_eq("rst_swap_ack_after", 32'(swap_ack), 32'h0);
        chk_eq("rst_disp_buf", 32'(rd_addr), 32'd0);
        chk_eq("rst_rd_en_after", 32'(rd_en), 32'h1);

        // Sync-only sweep in blanking: outputs are the inputs three cycles late, rgb stays black.
        x = 11'd1300; y = 11'd1030;
        for (int i = 0; i < 40; i++) begin
            hs_in = ((i % 5) == 1 || (i % 5) == 2) ? 1'b0 : 1'b1;
            vs_in = ((i % 9) >= 4) ? 1'b0 : 1'b1;
            hs_hist[i] = int'(hs_in);
            vs_hist[i] = int'(vs_in);
            tick();
            if (i >= 2) begin
                chk_eq("sweep_hsync", 32'(hs_out), hs_hist[i-2]);
                chk_eq("sweep_vsync", 32'(vs_out), vs_hist[i-2]);
                chk_eq("sweep_rgb", 32'(rgb), 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
